// File: rtl/regalumem_pkg.sv
// Shared op-codes, stage control fields and decode helpers for the regalumem pipeline.
package regalumem_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_SLT  = 3'd4;
  localparam logic [2:0] OP_ADDI = 3'd5;
  localparam logic [2:0] OP_LW   = 3'd6;
  localparam logic [2:0] OP_SW   = 3'd7;

  // Width-independent part of a stage register; data-width fields live in the top.
  typedef struct packed {
    logic        valid;
    logic [2:0]  op;
    logic [15:0] imm;
  } stage_ctrl_t;

  function automatic logic writes_reg(input logic [2:0] op);
    return op != OP_SW;
  endfunction

  function automatic logic uses_rt(input logic [2:0] op);
    return (op <= OP_SLT) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/regalumem_regfile.sv
// Register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
module regalumem_regfile
  import regalumem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [REG_ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0]     rdata_a,
  input  logic [REG_ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0]     rdata_b,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]     wdata
);

  localparam int unsigned Depth = 2 ** REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [Depth];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '{default: '0};
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/regalumem_pipe.sv
// Three-stage register-file / ALU / data-memory pipeline with forwarding and load-use stall.
module regalumem_pipe
  import regalumem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_ADDR_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                op,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rt,
  input  logic [15:0]               immediate,
  output logic                      out_valid,
  output logic                      out_we,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [DATA_WIDTH-1:0]     out_result
);

  localparam int unsigned MemDepth = 2 ** MEM_ADDR_WIDTH;

  typedef struct packed {
    stage_ctrl_t               ctrl;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     a;
    logic [DATA_WIDTH-1:0]     b;
  } s1_t;

  typedef struct packed {
    logic                      valid;
    logic [2:0]                op;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     res;
    logic [DATA_WIDTH-1:0]     data;
  } s2_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic [DATA_WIDTH-1:0] mem [MemDepth];

  logic [DATA_WIDTH-1:0] rf_a, rf_b;
  logic [DATA_WIDTH-1:0] opa, opb;
  logic [DATA_WIDTH-1:0] imm_ext, addr_sum, alu_res, wb_val;
  logic                  s1_fwd, s2_fwd, load_use, accept;

  regalumem_regfile #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .raddr_a (rs),
    .rdata_a (rf_a),
    .raddr_b (rt),
    .rdata_b (rf_b),
    .we      (s2_fwd),
    .waddr   (s2_q.rd),
    .wdata   (wb_val)
  );

  // ALU evaluates the S1 instruction; memory ops produce their address here.
  always_comb begin
    imm_ext  = DATA_WIDTH'(signed'(s1_q.ctrl.imm));
    addr_sum = s1_q.a + imm_ext;
    case (s1_q.ctrl.op)
      OP_ADD:  alu_res = s1_q.a + s1_q.b;
      OP_SUB:  alu_res = s1_q.a - s1_q.b;
      OP_AND:  alu_res = s1_q.a & s1_q.b;
      OP_OR:   alu_res = s1_q.a | s1_q.b;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(s1_q.a) < $signed(s1_q.b))};
      default: alu_res = addr_sum;
    endcase
  end

  assign wb_val = (s2_q.op == OP_LW) ? mem[s2_q.res[MEM_ADDR_WIDTH-1:0]] : s2_q.res;

  assign s1_fwd = s1_q.ctrl.valid && writes_reg(s1_q.ctrl.op) && (s1_q.rd != '0);
  assign s2_fwd = s2_q.valid && writes_reg(s2_q.op) && (s2_q.rd != '0);

  always_comb begin
    opa = rf_a;
    if (s1_fwd && (s1_q.rd == rs)) begin
      opa = alu_res;
    end else if (s2_fwd && (s2_q.rd == rs)) begin
      opa = wb_val;
    end
    opb = rf_b;
    if (s1_fwd && (s1_q.rd == rt)) begin
      opb = alu_res;
    end else if (s2_fwd && (s2_q.rd == rt)) begin
      opb = wb_val;
    end
  end

  // A load in S1 has no data yet, so a dependent instruction waits one cycle.
  assign load_use = s1_fwd && (s1_q.ctrl.op == OP_LW) &&
                    ((rs == s1_q.rd) || (uses_rt(op) && (rt == s1_q.rd)));
  assign in_ready = reset_n && !load_use;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_d.ctrl.valid = accept;
    s1_d.ctrl.op    = op;
    s1_d.ctrl.imm   = immediate;
    s1_d.rd         = rd;
    s1_d.a          = opa;
    s1_d.b          = opb;

    s2_d.valid = s1_q.ctrl.valid;
    s2_d.op    = s1_q.ctrl.op;
    s2_d.rd    = s1_q.rd;
    s2_d.res   = alu_res;
    s2_d.data  = s1_q.b;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      out_valid  <= 1'b0;
      out_we     <= 1'b0;
      out_rd     <= '0;
      out_result <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      out_valid  <= s2_q.valid;
      out_we     <= s2_fwd;
      out_rd     <= s2_fwd ? s2_q.rd : '0;
      if (!s2_q.valid) begin
        out_result <= '0;
      end else if (s2_q.op == OP_SW) begin
        out_result <= s2_q.data;
      end else begin
        out_result <= wb_val;
      end
    end
  end

  // Data memory is deliberately not reset; a cleared S2 suppresses pending stores.
  always_ff @(posedge clock) begin
    if (s2_q.valid && (s2_q.op == OP_SW)) begin
      mem[s2_q.res[MEM_ADDR_WIDTH-1:0]] <= s2_q.data;
    end
  end

endmodule
